vend_payout: RTL and testbench

- Actuator controller on the far side of the vending FSM's command outputs.
- Consumes the single-cycle dispense and ret pulses and drives the product motor and the coin-return hopper with timed pulses.
- Confirms each action via sensor inputs and reports completion, busy and fault status back to the vending logic and to the panel.

---
 rtl/vend_payout.sv | 179 +++++++++++++++++
 tb/tb_vend_payout.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vend_payout.sv
// Actuator controller behind the vending FSM: runs the product motor and the
// coin hopper as timed jobs, confirms them through sensors, reports done/busy/fault.
module vend_payout #(
  parameter int MOTOR_CYCLES = 16,
  parameter int VEND_TIMEOUT = 64,
  parameter int HOPPER_ON    = 4,
  parameter int HOPPER_OFF   = 4,
  parameter int RET_COINS    = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic dispense,
  input  logic ret,
  input  logic vend_sense,
  input  logic coin_sense,
  output logic motor,
  output logic hopper,
  output logic busy,
  output logic done,
  output logic fault
);

  localparam int M01  = (MOTOR_CYCLES > VEND_TIMEOUT) ? MOTOR_CYCLES : VEND_TIMEOUT;
  localparam int M23  = (HOPPER_ON > HOPPER_OFF) ? HOPPER_ON : HOPPER_OFF;
  localparam int MAXP = (M01 > M23) ? M01 : M23;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int NW   = $clog2(RET_COINS + 1);

  localparam logic [CW-1:0] MOT_LAST  = CW'(MOTOR_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(VEND_TIMEOUT - 1);
  localparam logic [CW-1:0] HON_LAST  = CW'(HOPPER_ON - 1);
  localparam logic [CW-1:0] HOFF_LAST = CW'(HOPPER_OFF - 1);
  localparam logic [NW-1:0] COIN_LAST = NW'(RET_COINS - 1);

  typedef enum logic [2:0] {
    IDLE, VEND_RUN, VEND_WAIT, PAY_ON, PAY_OFF, FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] coins_q, coins_d;
  logic          vseen_q, vseen_d;
  logic          cseen_q, cseen_d;
  logic          dpend_q, dpend_d;
  logic          rpend_q, rpend_d;
  logic          done_d, finish;
  logic          motor_q, hopper_q, busy_q, done_q, fault_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    coins_d = coins_q;
    vseen_d = vseen_q;
    cseen_d = cseen_q;
    dpend_d = dpend_q;
    rpend_d = rpend_q;
    done_d  = 1'b0;
    finish  = 1'b0;

    // One-deep request capture while a job runs; duplicates collapse.
    if (state_q != IDLE && state_q != FAULT) begin
      if (dispense) dpend_d = 1'b1;
      if (ret)      rpend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dispense) begin
          state_d = VEND_RUN;
          vseen_d = 1'b0;
          rpend_d = ret;
        end else if (ret) begin
          state_d = PAY_ON;
          coins_d = '0;
          cseen_d = 1'b0;
        end
      end
      VEND_RUN: begin
        vseen_d = vseen_q | vend_sense;
        if (cnt_q == MOT_LAST) begin
          if (vseen_d) finish = 1'b1;
          else begin
            state_d = VEND_WAIT;
            cnt_d   = '0;
          end
        end
      end
      VEND_WAIT: begin
        if (vend_sense) finish = 1'b1;
        else if (cnt_q == TO_LAST) state_d = FAULT;
      end
      PAY_ON: begin
        cseen_d = cseen_q | coin_sense;
        if (cnt_q == HON_LAST) begin
          state_d = PAY_OFF;
          cnt_d   = '0;
        end
      end
      PAY_OFF: begin
        cseen_d = cseen_q | coin_sense;
        if (cnt_q == HOFF_LAST) begin
          if (!cseen_d) state_d = FAULT;
          else if (coins_q == COIN_LAST) finish = 1'b1;
          else begin
            coins_d = coins_q + 1'b1;
            cseen_d = 1'b0;
            state_d = PAY_ON;
            cnt_d   = '0;
          end
        end
      end
      FAULT: cnt_d = cnt_q;
      default: state_d = FAULT;
    endcase

    if (state_d == FAULT) begin
      cnt_d   = '0;
      dpend_d = 1'b0;
      rpend_d = 1'b0;
    end

    // Completion chains straight into the next pending job, vend first.
    if (finish) begin
      done_d = 1'b1;
      cnt_d  = '0;
      if (dpend_d) begin
        state_d = VEND_RUN;
        dpend_d = 1'b0;
        vseen_d = 1'b0;
      end else if (rpend_d) begin
        state_d = PAY_ON;
        rpend_d = 1'b0;
        coins_d = '0;
        cseen_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      coins_q  <= '0;
      vseen_q  <= 1'b0;
      cseen_q  <= 1'b0;
      dpend_q  <= 1'b0;
      rpend_q  <= 1'b0;
      motor_q  <= 1'b0;
      hopper_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      coins_q  <= coins_d;
      vseen_q  <= vseen_d;
      cseen_q  <= cseen_d;
      dpend_q  <= dpend_d;
      rpend_q  <= rpend_d;
      // Outputs trail the state by one cycle; done lines up with the last drive cycle.
      motor_q  <= (state_q == VEND_RUN);
      hopper_q <= (state_q == PAY_ON);
      busy_q   <= (state_q != IDLE);
      fault_q  <= (state_q == FAULT);
      done_q   <= done_d;
    end
  end

  assign motor  = motor_q;
  assign hopper = hopper_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_vend_payout.sv
// Randomized and directed bench for vend_payout against a job-timeline
// reference model (elapsed time per job, arithmetic on coin windows).
module tb_vend_payout;
  localparam int MC = 16, TO = 64, HON = 4, HOFF = 4, RC = 3, P = HON + HOFF;

  logic clock = 1'b0;
  logic reset = 1'b1, dispense = 1'b0, ret = 1'b0, vend_sense = 1'b0, coin_sense = 1'b0;
  logic motor, hopper, busy, done, fault;

  always #5 clock = ~clock;

  vend_payout #(.MOTOR_CYCLES(MC), .VEND_TIMEOUT(TO), .HOPPER_ON(HON),
                .HOPPER_OFF(HOFF), .RET_COINS(RC)) dut (
    .clock(clock), .reset(reset), .dispense(dispense), .ret(ret),
    .vend_sense(vend_sense), .coin_sense(coin_sense),
    .motor(motor), .hopper(hopper), .busy(busy), .done(done), .fault(fault));

  int n_cmp = 0, n_err = 0;
  int motor_cnt, hopper_cnt, done_cnt;

  // model: job 0 idle, 1 vend, 2 payout, 3 fault; t = cycles elapsed in job
  int m_job = 0, m_t = 0;
  bit m_seen = 0, m_pd = 0, m_pr = 0;
  bit e_motor, e_hopper, e_busy, e_done, e_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_vend();
    m_job = 1; m_t = 0; m_seen = 0;
  endtask

  task automatic start_pay();
    m_job = 2; m_t = 0; m_seen = 0;
  endtask

  task automatic model_step(input bit r, input bit d, input bit rt, input bit vs, input bit cs);
    bit comp, flt;
    if (r) begin
      {e_motor, e_hopper, e_busy, e_done, e_fault} = '0;
      m_job = 0; m_t = 0; m_seen = 0; m_pd = 0; m_pr = 0;
      return;
    end
    e_busy   = (m_job != 0);
    e_fault  = (m_job == 3);
    e_motor  = (m_job == 1) && (m_t < MC);
    e_hopper = (m_job == 2) && ((m_t % P) < HON);
    e_done   = 0;
    comp = 0; flt = 0;
    if (m_job == 1 || m_job == 2) begin
      if (d)  m_pd = 1;
      if (rt) m_pr = 1;
    end
    case (m_job)
      0: if (d) begin start_vend(); m_pr = rt; end else if (rt) start_pay();
      1: begin
        if (m_t < MC) begin
          m_seen |= vs;
          if (m_t == MC - 1 && m_seen) comp = 1;
        end else if (vs) comp = 1;
        else if (m_t == MC + TO - 1) flt = 1;
        m_t++;
      end
      2: begin
        m_seen |= cs;
        if (m_t % P == P - 1) begin
          if (!m_seen) flt = 1;
          else if (m_t / P == RC - 1) comp = 1;
          else m_seen = 0;
        end
        m_t++;
      end
      default: ;
    endcase
    if (flt) begin m_job = 3; m_pd = 0; m_pr = 0; end
    if (comp) begin
      e_done = 1;
      if (m_pd) begin m_pd = 0; start_vend(); end
      else if (m_pr) begin m_pr = 0; start_pay(); end
      else m_job = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit d, input bit rt, input bit vs, input bit cs);
    reset = r; dispense = d; ret = rt; vend_sense = vs; coin_sense = cs;
    @(posedge clock);
    model_step(r, d, rt, vs, cs);
    #1;
    chk("motor",  motor,  e_motor);
    chk("hopper", hopper, e_hopper);
    chk("busy",   busy,   e_busy);
    chk("done",   done,   e_done);
    chk("fault",  fault,  e_fault);
    motor_cnt  += int'(motor);
    hopper_cnt += int'(hopper);
    done_cnt   += int'(done);
  endtask

  task automatic clr_cnt();
    motor_cnt = 0; hopper_cnt = 0; done_cnt = 0;
  endtask

  task automatic scen_vend_ok();
    clr_cnt();
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 24; i++) cyc(0, 0, 0, i == 4, 0);
    chk("s1_motor_cycles", motor_cnt, MC);
    chk("s1_done_count", done_cnt, 1);
  endtask

  initial begin
    clr_cnt();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_busy", busy, 0);

    scen_vend_ok();

    // vend never sensed -> timeout fault, held until reset
    clr_cnt();
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < MC + TO + 10; i++) cyc(0, i == 90, i == 85, 0, 0);
    chk("s2_fault_sticky", fault, 1);
    chk("s2_busy_sticky", busy, 1);
    chk("s2_no_done", done_cnt, 0);
    cyc(1, 0, 0, 0, 0);
    chk("s2_fault_cleared", fault, 0);

    // multi-coin payout
    clr_cnt();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, (i % P) == 1);
    chk("s3_hopper_cycles", hopper_cnt, RC * HON);
    chk("s3_done_count", done_cnt, 1);

    // dispense and ret together
    clr_cnt();
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < MC + RC * P + 6; i++) cyc(0, 0, 0, 1, 1);
    chk("s4_done_count", done_cnt, 2);
    chk("s4_hopper_cycles", hopper_cnt, RC * HON);

    // repeated ret during vend collapses to one payout
    clr_cnt();
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < MC + 2 * RC * P; i++) cyc(0, 0, i == 2 || i == 5 || i == 8, 1, 1);
    chk("s5_done_count", done_cnt, 2);
    chk("s5_hopper_cycles", hopper_cnt, RC * HON);

    // reset in the 2nd hopper cycle
    clr_cnt();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("s6_hopper_off", hopper, 0);
    chk("s6_busy_off", busy, 0);
    chk("s6_no_done", done_cnt, 0);
    cyc(0, 0, 0, 0, 0);
    scen_vend_ok();

    // randomized traffic
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
